// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - full-duplex UART transceiver with TX/RX FIFOs and valid/ready byte streams
//
// Optional feature macro: UART_PARITY_EN (even parity bit after the data bits).
// Ports:
//   clk, rst                       system clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready      byte stream into the TX FIFO
//   rx_data/rx_valid/rx_ready      byte stream out of the RX FIFO (first-word fall-through)
//   uart_tx / uart_rx              serial line out / in (idle high, uart_rx asynchronous)
//   tx_busy                        transmitter active or TX FIFO holding data
//   rx_frame_err/rx_overrun/rx_parity_err  single-cycle receive error pulses

module uart_xcvr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_wr;
    logic             do_rd;

    // Flags come from the registered occupancy only.
    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_xcvr #(
    parameter int FREQ       = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    output logic                 tx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_parity_err
);
    localparam int BIT_CLKS = (FREQ + BAUD / 2) / BAUD;
    localparam int CW       = $clog2(BIT_CLKS);
    localparam int IW       = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT
    } rx_state_t;

    // ---------------- transmit path ----------------
    logic                 tx_full;
    logic                 tx_empty;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_pop;

    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [IW-1:0]        tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_line, tx_line_n;
`ifdef UART_PARITY_EN
    logic                 tx_par, tx_par_n;
`endif

    uart_xcvr_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (tx_data),
        .wr_en   (tx_valid),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign tx_ready = !tx_full;
    assign tx_busy  = (tx_state != TX_IDLE) || !tx_empty;
    assign uart_tx  = tx_line;

    // The line flop is loaded with the value of the bit being entered, so
    // uart_tx changes on the same edge as the state and stays glitch-free.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n  = '0;
                tx_line_n = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
`ifdef UART_PARITY_EN
                    tx_par_n   = ^tx_head;
`endif
                    tx_state_n = TX_START;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = TX_DATA;
                    tx_line_n  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        tx_state_n = TX_PARITY;
                        tx_line_n  = tx_par;
`else
                        tx_state_n = TX_STOP;
                        tx_line_n  = 1'b1;
`endif
                    end else begin
                        tx_idx_n  = tx_idx + IW'(1);
                        tx_line_n = tx_shift[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_STOP;
                    tx_line_n  = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_head;
`ifdef UART_PARITY_EN
                        tx_par_n   = ^tx_head;
`endif
                        tx_state_n = TX_START;
                        tx_line_n  = 1'b0;
                    end else begin
                        tx_state_n = TX_IDLE;
                        tx_line_n  = 1'b1;
                    end
                end
            end
            default: begin
                tx_cnt_n   = '0;
                tx_state_n = TX_IDLE;
                tx_line_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    // ---------------- receive path ----------------
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 rx_full;
    logic                 rx_empty;

    rx_state_t            rx_state, rx_state_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [IW-1:0]        rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_push, rx_push_n;
    logic                 ferr_q, ferr_n;
    logic                 ovr_q;
`ifdef UART_PARITY_EN
    logic                 par_bad, par_bad_n;
    logic                 perr_q, perr_n;
`endif

    // Push is registered so the byte enters the FIFO the cycle after the
    // stop sample; rx_shift is untouched until the next frame's data bits.
    uart_xcvr_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (rx_shift),
        .wr_en   (rx_push),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign rx_valid     = !rx_empty;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_push_n  = 1'b0;
        ferr_n     = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_n  = par_bad;
        perr_n     = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                // Mid start bit: a line back high means the edge was a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n = '0;
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_idx_n   = '0;
                        rx_state_n = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_n = RX_PARITY;
`else
                        rx_state_n = RX_STOP;
`endif
                    end else begin
                        rx_idx_n = rx_idx + IW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    par_bad_n  = rx_sync ^ (^rx_shift);
                    rx_state_n = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    if (!rx_sync) begin
                        ferr_n     = 1'b1;
                        rx_state_n = RX_WAIT;
                    end else begin
`ifdef UART_PARITY_EN
                        if (par_bad) begin
                            perr_n = 1'b1;
                        end else begin
                            rx_push_n = 1'b1;
                        end
`else
                        rx_push_n = 1'b1;
`endif
                        rx_state_n = RX_IDLE;
                    end
                end
            end
            RX_WAIT: begin
                // A low stop bit leaves the line low; only re-arm once it idles.
                rx_cnt_n = '0;
                if (rx_sync) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: begin
                rx_cnt_n   = '0;
                rx_state_n = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_push  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad  <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_push  <= rx_push_n;
            ferr_q   <= ferr_n;
            // A push into a full FIFO is dropped regardless of a same-cycle pop.
            ovr_q    <= rx_push && rx_full;
`ifdef UART_PARITY_EN
            par_bad  <= par_bad_n;
            perr_q   <= perr_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - directed self-checking bench for uart_xcvr
module tb_uart_xcvr;
    localparam int FREQ  = 1_600_000;
    localparam int BAUD  = 100_000;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int BIT   = 16;
`ifdef UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          uart_tx;
    logic          uart_rx;
    logic          tx_busy;
    logic          rx_frame_err;
    logic          rx_overrun;
    logic          rx_parity_err;

    logic          rx_drv = 1'b1;
    logic          loopback = 1'b0;

    assign uart_rx = loopback ? uart_tx : rx_drv;

    uart_xcvr #(
        .FREQ       (FREQ),
        .BAUD       (BAUD),
        .DATA_BITS  (DB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .uart_tx       (uart_tx),
        .uart_rx       (uart_rx),
        .tx_busy       (tx_busy),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_parity_err (rx_parity_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    int perr_total = 0;

    always @(posedge clk) begin
        if (rx_frame_err)  ferr_cnt++;
        if (rx_overrun)    ovr_cnt++;
        if (rx_parity_err) begin
            perr_cnt++;
            perr_total++;
        end
    end

    logic [DB-1:0] rxq[$];
    logic          collect = 1'b0;
    always @(posedge clk) begin
        if (collect && rx_valid && rx_ready) rxq.push_back(rx_data);
    end

    logic meas = 1'b0;
    logic started = 1'b0;
    int   busy_cycles = 0;
    always @(negedge clk) begin
        if (meas) begin
            if (!started && !uart_tx) started = 1'b1;
            if (started && tx_busy) busy_cycles++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        ferr_cnt = 0;
        ovr_cnt  = 0;
        perr_cnt = 0;
    endtask

    function automatic logic [8:0] fr(input logic [7:0] d, input logic par_ok);
        return {(^d) ^ ~par_ok, d};
    endfunction

    // bits[8] is the parity bit, only driven when parity is compiled in.
    task automatic send_frame(input logic [8:0] bits, input logic stop_b);
        rx_drv = 1'b0;
        cyc(BIT);
        for (int i = 0; i < FRAME - 2; i++) begin
            rx_drv = bits[i];
            cyc(BIT);
        end
        rx_drv = stop_b;
        cyc(BIT);
        rx_drv = 1'b1;
    endtask

    task automatic wait_rx(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        logic [FRAME-1:0] exp_bits;
        int         stall;
        int         early_stall;
        int         lows;

        // reset state
        cyc(4);
        chk("rst uart_tx", uart_tx, 1);
        chk("rst tx_ready", tx_ready, 1);
        chk("rst rx_valid", rx_valid, 0);
        chk("rst tx_busy", tx_busy, 0);
        chk("rst err pulses", {rx_frame_err, rx_overrun, rx_parity_err}, 0);
        rst = 1'b0;
        cyc(2);

        // loopback 0xA5: latency, bit order and bit duration
        loopback = 1'b1;
        clr();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        chk("tx latency N+1 high", uart_tx, 1);
        cyc(1);
        chk("tx latency N+2 low", uart_tx, 0);
        exp_bits = '0;
        for (int i = 0; i < DB; i++) exp_bits[1 + i] = tx_data[i];
`ifdef UART_PARITY_EN
        exp_bits[FRAME-2] = ^tx_data;
`endif
        exp_bits[FRAME-1] = 1'b1;
        cyc(BIT - 1);
        chk("start bit last clk", uart_tx, 0);
        cyc(1);
        chk("bit0 first clk", uart_tx, 1);
        cyc(BIT / 2);
        for (int b = 1; b < FRAME; b++) begin
            chk($sformatf("A5 line bit %0d", b), uart_tx, exp_bits[b]);
            cyc(BIT);
        end
        wait_rx(4 * BIT, ok);
        chk("A5 rx_valid", ok, 1);
        chk("A5 rx_data", rx_data, 8'hA5);
        chk("A5 err pulses", ferr_cnt + ovr_cnt + perr_cnt, 0);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        chk("A5 popped", rx_valid, 0);

        // back-to-back TX: 17 pushes fill the FIFO, the 18th waits for a slot
        rxq.delete();
        collect  = 1'b1;
        rx_ready = 1'b1;
        busy_cycles = 0;
        started  = 1'b0;
        meas     = 1'b1;
        early_stall = 0;
        for (int i = 0; i < 17; i++) begin
            tx_data  = 8'(i);
            tx_valid = 1'b1;
            while (!tx_ready && early_stall < 1000) begin
                early_stall++;
                cyc(1);
            end
            cyc(1);
        end
        chk("first 17 no stall", early_stall, 0);
        chk("tx full after 17", tx_ready, 0);
        tx_data = 8'h11;
        stall = 0;
        while (!tx_ready && stall < 4 * FRAME * BIT) begin
            stall++;
            cyc(1);
        end
        cyc(1);
        tx_valid = 1'b0;
        chk("18th stall cycles", stall, FRAME * BIT - 15);
        for (int i = 0; i < 20 * FRAME * BIT && (rxq.size() < 18 || tx_busy); i++) cyc(1);
        cyc(2);
        meas = 1'b0;
        chk("b2b rx count", rxq.size(), 18);
        for (int i = 0; i < 18 && i < rxq.size(); i++) chk($sformatf("b2b byte %0d", i), rxq[i], i);
        chk("b2b no idle gap", busy_cycles, 18 * FRAME * BIT);
        chk("b2b err pulses", ferr_cnt + ovr_cnt + perr_cnt, 0);
        collect  = 1'b0;
        rx_ready = 1'b0;

        // RX overrun: 17 frames with rx_ready low
        loopback = 1'b0;
        rx_drv   = 1'b1;
        cyc(BIT);
        clr();
        for (int i = 0; i < 17; i++) send_frame(fr(8'(8'h40 + i), 1'b1), 1'b1);
        cyc(2 * BIT);
        chk("overrun pulses", ovr_cnt, 1);
        chk("overrun rx_valid", rx_valid, 1);
        chk("overrun head", rx_data, 8'h40);
        chk("overrun frame err", ferr_cnt, 0);
        rxq.delete();
        collect  = 1'b1;
        rx_ready = 1'b1;
        cyc(20);
        rx_ready = 1'b0;
        collect  = 1'b0;
        chk("overrun drained count", rxq.size(), 16);
        for (int i = 0; i < 16 && i < rxq.size(); i++) chk($sformatf("overrun byte %0d", i), rxq[i], 8'h40 + i);

        // framing error then recovery
        clr();
        send_frame(fr(8'h3C, 1'b1), 1'b0);
        cyc(2 * BIT);
        chk("frame err pulses", ferr_cnt, 1);
        chk("frame err rx_valid", rx_valid, 0);
        send_frame(fr(8'h55, 1'b1), 1'b1);
        cyc(BIT);
        chk("post-ferr rx_valid", rx_valid, 1);
        chk("post-ferr rx_data", rx_data, 8'h55);
        chk("post-ferr pulses", ferr_cnt, 1);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;

        // glitch shorter than half a bit
        clr();
        rx_drv = 1'b0;
        cyc(5);
        rx_drv = 1'b1;
        cyc(2 * FRAME * BIT);
        chk("glitch rx_valid", rx_valid, 0);
        chk("glitch err pulses", ferr_cnt + ovr_cnt + perr_cnt, 0);

`ifdef UART_PARITY_EN
        // parity error drops the byte
        clr();
        send_frame(fr(8'h07, 1'b0), 1'b1);
        cyc(BIT);
        chk("parity err pulses", perr_cnt, 1);
        chk("parity err rx_valid", rx_valid, 0);
        send_frame(fr(8'h07, 1'b1), 1'b1);
        cyc(BIT);
        chk("parity ok rx_data", rx_data, 8'h07);
        chk("parity ok pulses", perr_cnt, 1);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
`else
        chk("parity err never", perr_total, 0);
`endif

        // reset in the middle of a TX frame with both FIFOs holding data
        clr();
        send_frame(fr(8'h99, 1'b1), 1'b1);
        cyc(BIT);
        chk("pre-rst rx_valid", rx_valid, 1);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        cyc(1);
        tx_data  = 8'h01;
        cyc(1);
        tx_valid = 1'b0;
        cyc(5 * BIT);
        chk("pre-rst uart_tx", uart_tx, 0);
        chk("pre-rst tx_busy", tx_busy, 1);
        rst = 1'b1;
        cyc(1);
        chk("mid rst uart_tx", uart_tx, 1);
        chk("mid rst tx_busy", tx_busy, 0);
        chk("mid rst tx_ready", tx_ready, 1);
        chk("mid rst rx_valid", rx_valid, 0);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 2 * FRAME * BIT; i++) begin
            cyc(1);
            if (!uart_tx) lows++;
        end
        chk("post-rst line idle", lows, 0);
        chk("post-rst tx_busy", tx_busy, 0);
        chk("post-rst rx_valid", rx_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
